// File: rtl/light_bar_anim.sv
// light_bar_anim
//   VGA overlay that draws a horizontal row of N_CELLS bordered cells and
//   animates their interiors in one of three frame-synchronised patterns:
//   fill (bar grows left to right), chase (single lit cell walks right and
//   wraps) and bounce (single lit cell ping-pongs). Mode 3 blanks every
//   interior while the borders keep drawing.
//
// Ports
//   clk       in   pixel-domain clock
//   reset     in   synchronous, active-high reset
//   pix_x     in   [9:0] current pixel column
//   pix_y     in   [9:0] current pixel row
//   video_on  in   active-display flag
//   enable    in   animation advances when high, freezes when low
//   mode      in   [1:0] 0 fill, 1 chase, 2 bounce, 3 frozen-off
//   lit_rgb   in   [11:0] colour of lit interiors
//   rgb       out  [11:0] registered overlay pixel (1 clk latency)
//   step      out  [SW-1:0] current step index
//   wrap      out  one-cycle pulse at pattern wrap or bounce reversal

module light_bar_anim #(
    parameter int          N_CELLS         = 5,
    parameter int          X0              = 464,
    parameter int          Y0              = 279,
    parameter int          CELL_W          = 21,
    parameter int          CELL_H          = 13,
    parameter int          PITCH           = 22,
    parameter int          BORDER          = 2,
    parameter int          FRAMES_PER_STEP = 12,
    parameter logic [11:0] BORDER_RGB      = 12'hFFF,
    localparam int         SW              = $clog2(N_CELLS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    pix_x,
    input  logic [9:0]    pix_y,
    input  logic          video_on,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [11:0]   lit_rgb,
    output logic [11:0]   rgb,
    output logic [SW-1:0] step,
    output logic          wrap
);

    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_OFF    = 2'd3
    } mode_t;

    // Frame counter needs at least one bit even when every frame is a step.
    localparam int          FW         = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(N_CELLS - 1);
    localparam logic [SW-1:0] STEP_MAX  = SW'(N_CELLS);

    // Cell row vertical extents are shared by all cells.
    localparam logic [9:0] Y_TOP   = 10'(Y0);
    localparam logic [9:0] Y_BOT   = 10'(Y0 + CELL_H - 1);
    localparam logic [9:0] YI_TOP  = 10'(Y0 + BORDER);
    localparam logic [9:0] YI_BOT  = 10'(Y0 + CELL_H - 1 - BORDER);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic          sof_flag_reg;
    logic [FW-1:0] fcnt_reg,   fcnt_next;
    logic [SW-1:0] step_reg,   step_next;
    logic          dir_up_reg, dir_up_next;
    logic          wrap_reg,   wrap_next;
    mode_t         mode_reg,   mode_next;
    logic [11:0]   rgb_reg,    rgb_next;

    logic at_origin;
    logic sof;
    logic advance;
    logic mode_changed;

    // sof fires only on the first clock of a (0,0) run, so a pixel tick
    // slower than clk still yields one frame pulse.
    assign at_origin    = (pix_x == 10'd0) && (pix_y == 10'd0);
    assign sof          = at_origin && !sof_flag_reg;
    assign mode_changed = (mode != mode_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            sof_flag_reg <= 1'b0;
            fcnt_reg     <= '0;
            step_reg     <= '0;
            dir_up_reg   <= 1'b1;
            wrap_reg     <= 1'b0;
            mode_reg     <= MODE_FILL;
            rgb_reg      <= 12'h000;
        end else begin
            sof_flag_reg <= at_origin;
            fcnt_reg     <= fcnt_next;
            step_reg     <= step_next;
            dir_up_reg   <= dir_up_next;
            wrap_reg     <= wrap_next;
            mode_reg     <= mode_next;
            rgb_reg      <= rgb_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter and step sequencing
    // ------------------------------------------------------------------
    always_comb begin
        fcnt_next   = fcnt_reg;
        step_next   = step_reg;
        dir_up_next = dir_up_reg;
        wrap_next   = 1'b0;
        mode_next   = mode_t'(mode);
        advance     = 1'b0;

        if (sof && enable) begin
            if (fcnt_reg == FCNT_LAST) begin
                fcnt_next = '0;
                advance   = 1'b1;
            end else begin
                fcnt_next = fcnt_reg + FW'(1);
            end
        end

        if (advance) begin
            case (mode_reg)
                MODE_FILL: begin
                    if (step_reg >= STEP_MAX) begin
                        step_next = '0;
                        wrap_next = 1'b1;
                    end else begin
                        step_next = step_reg + SW'(1);
                    end
                end
                MODE_CHASE: begin
                    if (step_reg >= STEP_LAST) begin
                        step_next = '0;
                        wrap_next = 1'b1;
                    end else begin
                        step_next = step_reg + SW'(1);
                    end
                end
                MODE_BOUNCE: begin
                    if (N_CELLS == 1) begin
                        // A single cell has nowhere to go; every step is a reversal.
                        step_next   = '0;
                        dir_up_next = !dir_up_reg;
                        wrap_next   = 1'b1;
                    end else if (dir_up_reg) begin
                        if (step_reg >= STEP_LAST) begin
                            dir_up_next = 1'b0;
                            step_next   = step_reg - SW'(1);
                            wrap_next   = 1'b1;
                        end else begin
                            step_next = step_reg + SW'(1);
                        end
                    end else begin
                        if (step_reg == '0) begin
                            dir_up_next = 1'b1;
                            step_next   = SW'(1);
                            wrap_next   = 1'b1;
                        end else begin
                            step_next = step_reg - SW'(1);
                        end
                    end
                end
                default: begin
                    // Frozen-off: the advance is swallowed.
                end
            endcase
        end

        // A new mode restarts the pattern cleanly and outranks any advance.
        if (mode_changed) begin
            fcnt_next   = '0;
            step_next   = '0;
            dir_up_next = 1'b1;
            wrap_next   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Per-cell geometry; all edges are elaboration-time constants.
    // ------------------------------------------------------------------
    logic [N_CELLS-1:0] lit_int_v;
    logic [N_CELLS-1:0] inner_v;
    logic [N_CELLS-1:0] border_v;

    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
        localparam logic [9:0]    X_L  = 10'(X0 + gi * PITCH);
        localparam logic [9:0]    X_R  = 10'(X0 + gi * PITCH + CELL_W - 1);
        localparam logic [9:0]    XI_L = 10'(X0 + gi * PITCH + BORDER);
        localparam logic [9:0]    XI_R = 10'(X0 + gi * PITCH + CELL_W - 1 - BORDER);
        localparam logic [SW-1:0] IDX  = SW'(gi);

        logic in_outer;
        logic in_inner;
        logic cell_on;

        assign in_outer = (pix_x >= X_L)    && (pix_x <= X_R) &&
                          (pix_y >= Y_TOP)  && (pix_y <= Y_BOT);
        assign in_inner = (pix_x >= XI_L)   && (pix_x <= XI_R) &&
                          (pix_y >= YI_TOP) && (pix_y <= YI_BOT);

        assign cell_on = (mode_reg == MODE_FILL)  ? (IDX < step_reg) :
                         ((mode_reg == MODE_CHASE) || (mode_reg == MODE_BOUNCE)) ?
                                                    (IDX == step_reg) : 1'b0;

        assign lit_int_v[gi] = in_inner && cell_on;
        assign inner_v[gi]   = in_inner;
        assign border_v[gi]  = in_outer && !in_inner;
    end

    // Cells never overlap, so OR-reducing the per-cell hits is unambiguous.
    always_comb begin
        rgb_next = 12'h000;
        if (!video_on) begin
            rgb_next = 12'h000;
        end else if (|lit_int_v) begin
            rgb_next = lit_rgb;
        end else if (|inner_v) begin
            rgb_next = 12'h000;
        end else if (|border_v) begin
            rgb_next = BORDER_RGB;
        end
    end

    assign rgb  = rgb_reg;
    assign step = step_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_light_bar_anim.sv
// Bench for light_bar_anim: directed frames with a closed-form model of the
// animation (step as a function of frames since restart) and a geometric
// pixel model, checked every cycle, plus hand-computed literal checkpoints.

module tb_light_bar_anim;

    localparam int N      = 5;
    localparam int X0     = 464;
    localparam int Y0     = 279;
    localparam int CW     = 21;
    localparam int CH     = 13;
    localparam int PITCH  = 22;
    localparam int B      = 2;
    localparam int FPS    = 2;
    localparam logic [11:0] BRGB = 12'hFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pix_x, pix_y;
    logic        video_on;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] lit_rgb;
    logic [11:0] rgb;
    logic [2:0]  step;
    logic        wrap;

    int n_vec  = 0;
    int n_fail = 0;
    int wrap_cnt = 0;

    light_bar_anim #(
        .N_CELLS(N), .X0(X0), .Y0(Y0), .CELL_W(CW), .CELL_H(CH),
        .PITCH(PITCH), .BORDER(B), .FRAMES_PER_STEP(FPS), .BORDER_RGB(BRGB)
    ) dut (
        .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
        .video_on(video_on), .enable(enable), .mode(mode), .lit_rgb(lit_rgb),
        .rgb(rgb), .step(step), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [11:0] act, logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- model ----------------
    function automatic int tri_pos(int k);
        int p;
        if (N == 1) return 0;
        p = k % (2 * (N - 1));
        return (p < N) ? p : 2 * (N - 1) - p;
    endfunction

    function automatic int step_of(int md, int k);
        case (md)
            0: return k % (N + 1);
            1: return k % N;
            2: return tri_pos(k);
            default: return 0;
        endcase
    endfunction

    // Wrap on advance number k (k >= 1).
    function automatic bit wraps(int md, int k);
        case (md)
            0, 1: return step_of(md, k) == 0;
            2: begin
                if (N == 1) return 1'b1;
                if (k < 2) return 1'b0;
                return (tri_pos(k) - tri_pos(k-1)) != (tri_pos(k-1) - tri_pos(k-2));
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [11:0] pix_model(int x, int y, bit vo, logic [11:0] lit,
                                              int md, int st);
        int  xl;
        bit  outer, inner, on;
        if (!vo) return 12'h000;
        for (int i = 0; i < N; i++) begin
            xl    = X0 + i * PITCH;
            outer = (x >= xl) && (x <= xl + CW - 1) && (y >= Y0) && (y <= Y0 + CH - 1);
            inner = (x >= xl + B) && (x <= xl + CW - 1 - B) &&
                    (y >= Y0 + B) && (y <= Y0 + CH - 1 - B);
            on    = (md == 0) ? (i < st) : ((md == 1) || (md == 2)) ? (i == st) : 1'b0;
            if (inner) return on ? lit : 12'h000;
            if (outer) return BRGB;
        end
        return 12'h000;
    endfunction

    int          m_f = 0;      // enabled frames since last reset / mode change
    int          m_mode = 0;
    bit          m_prev = 0;
    bit          m_valid = 0;
    logic [11:0] exp_rgb = '0;
    logic [2:0]  exp_step = '0;
    logic        exp_wrap = 1'b0;

    always begin
        bit match, sof;
        @(posedge clk);
        if (reset) begin
            m_f = 0; m_mode = 0; m_prev = 0;
            exp_rgb = 12'h000; exp_wrap = 1'b0; m_valid = 1'b1;
        end else begin
            exp_rgb  = pix_model(int'(pix_x), int'(pix_y), video_on, lit_rgb,
                                 m_mode, step_of(m_mode, m_f / FPS));
            match    = (pix_x == 0) && (pix_y == 0);
            sof      = match && !m_prev;
            m_prev   = match;
            exp_wrap = 1'b0;
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode);
                m_f    = 0;
            end else if (sof && enable) begin
                m_f++;
                if (m_f % FPS == 0) exp_wrap = wraps(m_mode, m_f / FPS);
            end
        end
        exp_step = 3'(step_of(m_mode, m_f / FPS));
        #1;
        if (m_valid) begin
            chk("rgb",  rgb,           exp_rgb);
            chk("step", 12'(step),     12'(exp_step));
            chk("wrap", 12'(wrap),     12'(exp_wrap));
            if (wrap === 1'b1) wrap_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_pix(int x, int y);
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
    endtask

    // One frame: (0,0) held for 4 clocks, then a sweep of probe pixels.
    task automatic run_frame();
        int xl;
        @(negedge clk);
        video_on = 1'b1;
        pix_x = 10'd0; pix_y = 10'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            xl = X0 + i * PITCH;
            set_pix(xl,      Y0);
            set_pix(xl + 2,  Y0 + 2);
            set_pix(xl + 18, Y0 + 10);
            set_pix(xl + 19, Y0 + 6);
            set_pix(xl + 21, Y0 + 5);
            set_pix(xl + 5,  Y0 + 13);
        end
    endtask

    task automatic probe(string nm, int x, int y, bit vo, logic [11:0] exp);
        @(negedge clk);
        pix_x = 10'(x); pix_y = 10'(y); video_on = vo;
        @(posedge clk);
        #2;
        chk(nm, rgb, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fill_exp[13]  = '{0,1,1,2,2,3,3,4,4,5,5,0,0};
        int bnc_exp[10]   = '{1,2,3,4,3,2,1,0,1,2};

        reset = 1'b1; pix_x = 10'd5; pix_y = 10'd5; video_on = 1'b1;
        enable = 1'b0; mode = 2'd0; lit_rgb = 12'hF00;
        repeat (3) @(negedge clk);
        chk("reset_step", 12'(step), 12'h0);
        chk("reset_wrap", 12'(wrap), 12'h0);
        chk("reset_rgb",  rgb,       12'h000);
        reset = 1'b0;

        // Fill: 13 frames at 2 frames per step.
        enable = 1'b1;
        wrap_cnt = 0;
        for (int f = 0; f < 13; f++) begin
            run_frame();
            chk($sformatf("fill_step_f%0d", f + 1), 12'(step), 12'(fill_exp[f]));
        end
        chk("fill_wrap_count", 12'(wrap_cnt), 12'd1);

        // Walk fill to step 4, then one extra frame so fcnt is mid-count.
        repeat (7) run_frame();
        chk("fill_step4", 12'(step), 12'd4);
        run_frame();

        // Switch to chase: immediate restart, no wrap.
        @(negedge clk);
        mode = 2'd1;
        @(posedge clk);
        #2;
        chk("modechg_step", 12'(step), 12'd0);
        chk("modechg_wrap", 12'(wrap), 12'd0);
        run_frame();
        chk("chase_fcnt_cleared", 12'(step), 12'd0);
        repeat (3) run_frame();
        chk("chase_step2", 12'(step), 12'd2);

        probe("probe_cell2_lit", X0 + 2*PITCH + B, Y0 + B, 1'b1, 12'hF00);
        probe("probe_cell1_unlit", X0 + 1*PITCH + B, Y0 + B, 1'b1, 12'h000);
        probe("probe_border_origin", X0, Y0, 1'b1, 12'hFFF);
        probe("probe_video_off", X0 + 2*PITCH + B, Y0 + B, 1'b0, 12'h000);

        repeat (2) run_frame();
        chk("chase_step3", 12'(step), 12'd3);

        // Freeze for 5 frames.
        enable = 1'b0;
        repeat (5) run_frame();
        chk("frozen_step3", 12'(step), 12'd3);
        enable = 1'b1;
        run_frame();
        chk("reenable_1frame", 12'(step), 12'd3);
        run_frame();
        chk("reenable_2frames", 12'(step), 12'd4);

        // Frozen-off: interiors dark, borders white.
        @(negedge clk);
        mode = 2'd3;
        for (int i = 0; i < N; i++) begin
            probe($sformatf("off_int%0d", i), X0 + i*PITCH + 10, Y0 + 6, 1'b1, 12'h000);
            probe($sformatf("off_bdr%0d", i), X0 + i*PITCH + 1,  Y0 + 6, 1'b1, 12'hFFF);
        end
        repeat (2) run_frame();
        chk("off_step", 12'(step), 12'd0);

        // Bounce.
        @(negedge clk);
        mode = 2'd2;
        lit_rgb = 12'h0A5;
        wrap_cnt = 0;
        for (int a = 0; a < 10; a++) begin
            repeat (FPS) run_frame();
            chk($sformatf("bounce_adv%0d", a + 1), 12'(step), 12'(bnc_exp[a]));
        end
        chk("bounce_wrap_count", 12'(wrap_cnt), 12'd2);

        // Mid-frame reset, mode input still bounce.
        set_pix(500, Y0 + 3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_step", 12'(step), 12'd0);
        chk("midreset_rgb",  rgb,       12'h000);
        run_frame();
        chk("postreset_f1", 12'(step), 12'd0);
        run_frame();
        chk("postreset_f2", 12'(step), 12'd1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
